// File: rtl/exe_stage.sv
// Execute stage of the ARM-subset pipeline: Val2 shifter, ALU, NZCV register, branch target, iterative MUL.
// Define MUL_EARLY_TERM_EN to end multiplication as soon as the remaining multiplier bits are zero.
module exe_stage #(
  parameter int W        = 32,
  parameter int MUL_ITER = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   exe_cmd,
  input  logic         s,
  input  logic         b,
  input  logic         mem_r,
  input  logic         mem_w,
  input  logic         imm,
  input  logic [11:0]  shift_operand,
  input  logic [23:0]  signed_imm,
  input  logic [W-1:0] val_rn,
  input  logic [W-1:0] val_rm,
  input  logic [W-1:0] pc,
  input  logic         carry_in,
  output logic [W-1:0] alu_result,
  output logic [W-1:0] br_addr,
  output logic         branch_taken,
  output logic [3:0]   status,
  output logic         stall
);

  localparam int CW = $clog2(MUL_ITER + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MUL_ITER - 1);

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [3:0] CMD_MUL = 4'b1010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mul_state_e;

  mul_state_e     state_r, state_nxt_s;
  logic [W-1:0]   mcand_r, mplier_r, acc_r;
  logic [CW-1:0]  count_r;
  logic [3:0]     status_r;
  logic [W-1:0]   val2_s, res_s;
  logic [W:0]     sum_s;
  logic [3:0]     alu_op_s;
  logic           c_s, v_s, stall_s, is_mul_s, last_iter_s;

  function automatic logic [W-1:0] ror_w(input logic [W-1:0] x, input logic [4:0] n);
    logic [2*W-1:0] t;
    t = {x, x} >> n;
    return t[W-1:0];
  endfunction

  assign is_mul_s = (exe_cmd == CMD_MUL) && !(mem_r || mem_w);
  assign alu_op_s = (mem_r || mem_w) ? CMD_ADD : exe_cmd;

`ifdef MUL_EARLY_TERM_EN
  assign last_iter_s = (count_r == CNT_LAST) || (mplier_r[W-1:1] == '0);
`else
  assign last_iter_s = (count_r == CNT_LAST);
`endif

  // Val2: rotated immediate, memory offset, or shifted register
  always_comb begin
    val2_s = val_rm;
    if (imm) begin
      val2_s = ror_w({{(W-8){1'b0}}, shift_operand[7:0]}, {shift_operand[11:8], 1'b0});
    end else if (mem_r || mem_w) begin
      val2_s = {{(W-12){1'b0}}, shift_operand};
    end else begin
      case (shift_operand[6:5])
        2'b00:   val2_s = val_rm << shift_operand[11:7];
        2'b01:   val2_s = val_rm >> shift_operand[11:7];
        2'b10:   val2_s = $unsigned($signed(val_rm) >>> shift_operand[11:7]);
        2'b11:   val2_s = ror_w(val_rm, shift_operand[11:7]);
        default: val2_s = val_rm;
      endcase
    end
  end

  // ALU result and arithmetic flags; logic ops keep the stored C and V
  always_comb begin
    res_s = '0;
    sum_s = '0;
    c_s   = status_r[1];
    v_s   = status_r[0];
    case (alu_op_s)
      CMD_MOV: res_s = val2_s;
      CMD_MVN: res_s = ~val2_s;
      CMD_ADD, CMD_ADC: begin
        sum_s = {1'b0, val_rn} + {1'b0, val2_s}
              + {{W{1'b0}}, (alu_op_s == CMD_ADC) ? carry_in : 1'b0};
        res_s = sum_s[W-1:0];
        c_s   = sum_s[W];
        v_s   = (val_rn[W-1] == val2_s[W-1]) && (res_s[W-1] != val_rn[W-1]);
      end
      CMD_SUB, CMD_SBC: begin
        // a - b - borrow computed as a + ~b + carry so the carry-out is NOT borrow
        sum_s = {1'b0, val_rn} + {1'b0, ~val2_s}
              + {{W{1'b0}}, (alu_op_s == CMD_SBC) ? carry_in : 1'b1};
        res_s = sum_s[W-1:0];
        c_s   = sum_s[W];
        v_s   = (val_rn[W-1] != val2_s[W-1]) && (res_s[W-1] != val_rn[W-1]);
      end
      CMD_AND: res_s = val_rn & val2_s;
      CMD_ORR: res_s = val_rn | val2_s;
      CMD_EOR: res_s = val_rn ^ val2_s;
      CMD_MUL: res_s = acc_r;
      default: res_s = '0;
    endcase
  end

  // Multiplier FSM next state and stall; stall is masked while reset is asserted
  always_comb begin
    state_nxt_s = state_r;
    stall_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (is_mul_s) begin
          stall_s     = rst;
          state_nxt_s = ST_BUSY;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        stall_s = rst;
        if (last_iter_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_BUSY;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Shift-add multiplier datapath
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand_r  <= '0;
      mplier_r <= '0;
      acc_r    <= '0;
      count_r  <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (is_mul_s) begin
            mcand_r  <= val_rn;
            mplier_r <= val2_s;
            acc_r    <= '0;
            count_r  <= '0;
          end
        end
        ST_BUSY: begin
          if (mplier_r[0]) begin
            acc_r <= acc_r + mcand_r;
          end
          mcand_r  <= mcand_r << 1;
          mplier_r <= mplier_r >> 1;
          count_r  <= count_r + CNT_ONE;
        end
        default: ;
      endcase
    end
  end

  // NZCV register: updated only by non-branch, non-stalled instructions with s set
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      status_r <= 4'b0000;
    end else if (s && !stall_s && !b) begin
      status_r <= {res_s[W-1], (res_s == '0), c_s, v_s};
    end
  end

  assign alu_result   = res_s;
  assign br_addr      = pc + {{(W-26){signed_imm[23]}}, signed_imm, 2'b00};
  assign branch_taken = b & ~stall_s;
  assign status       = status_r;
  assign stall        = stall_s;

endmodule

// File: tb/tb_exe_stage.sv
// Randomised self-checking bench for exe_stage against a plain-arithmetic reference model.
module tb_exe_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  exe_cmd;
  logic        s, b, mem_r, mem_w, imm, carry_in;
  logic [11:0] shift_operand;
  logic [23:0] signed_imm;
  logic [31:0] val_rn, val_rm, pc;
  logic [31:0] alu_result, br_addr;
  logic        branch_taken, stall;
  logic [3:0]  status;

  int n_checks = 0;
  int n_errors = 0;
  logic [3:0] status_m = 4'b0000;

  exe_stage dut (
    .clk(clk), .rst(rst), .exe_cmd(exe_cmd), .s(s), .b(b), .mem_r(mem_r), .mem_w(mem_w),
    .imm(imm), .shift_operand(shift_operand), .signed_imm(signed_imm), .val_rn(val_rn),
    .val_rm(val_rm), .pc(pc), .carry_in(carry_in), .alu_result(alu_result), .br_addr(br_addr),
    .branch_taken(branch_taken), .status(status), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    logic [31:0] y;
    y = x;
    repeat (n) y = {y[0], y[31:1]};
    return y;
  endfunction

  function automatic logic [31:0] m_val2(input logic im, input logic mem, input logic [11:0] so,
                                         input logic [31:0] rm);
    logic [31:0] x;
    int n;
    int sv;
    if (im) return rotr({24'd0, so[7:0]}, 2 * int'(so[11:8]));
    if (mem) return {20'd0, so};
    n = int'(so[11:7]);
    x = rm;
    case (so[6:5])
      2'b00: repeat (n) x = x * 32'd2;
      2'b01: repeat (n) x = x / 32'd2;
      2'b10: begin sv = rm; sv = sv >>> n; x = sv; end
      default: x = rotr(rm, n);
    endcase
    return x;
  endfunction

  // Exact-integer model: carry/borrow and overflow from widened results
  task automatic model_alu(input logic [3:0] cmd, input logic [31:0] rn, input logic [31:0] v2,
                           input logic ci, output logic [31:0] r, output logic [3:0] nzcv);
    longint ua, ub, sa, sb, ur, sr, cv, bw;
    logic c, v;
    c = status_m[1]; v = status_m[0];
    ua = longint'({32'd0, rn}); ub = longint'({32'd0, v2});
    sa = longint'($signed(rn)); sb = longint'($signed(v2));
    cv = ci ? 64'sd1 : 64'sd0;
    bw = ci ? 64'sd0 : 64'sd1;
    r = 32'd0;
    case (cmd)
      4'b0001: r = v2;
      4'b1001: r = ~v2;
      4'b0010, 4'b0011: begin
        if (cmd == 4'b0010) cv = 64'sd0;
        ur = ua + ub + cv; sr = sa + sb + cv;
        r = ur[31:0]; c = (ur >= 64'sd4294967296);
        v = (sr != longint'($signed(r)));
      end
      4'b0100, 4'b0101: begin
        if (cmd == 4'b0100) bw = 64'sd0;
        ur = ua - ub - bw; sr = sa - sb - bw;
        r = ur[31:0]; c = (ur >= 64'sd0);
        v = (sr != longint'($signed(r)));
      end
      4'b0110: r = rn & v2;
      4'b0111: r = rn | v2;
      4'b1000: r = rn ^ v2;
      default: r = 32'd0;
    endcase
    nzcv = {r[31], r == 32'd0, c, v};
  endtask

  task automatic run_op(input logic [3:0] cmd, input logic si, input logic bi, input logic mr,
                        input logic mw, input logic im, input logic [11:0] so,
                        input logic [23:0] simm, input logic [31:0] rn, input logic [31:0] rm,
                        input logic [31:0] pcv, input logic ci);
    logic [31:0] v2, r, ba;
    logic [3:0] f;
    exe_cmd = cmd; s = si; b = bi; mem_r = mr; mem_w = mw; imm = im; shift_operand = so;
    signed_imm = simm; val_rn = rn; val_rm = rm; pc = pcv; carry_in = ci;
    v2 = m_val2(im, mr | mw, so, rm);
    model_alu((mr | mw) ? 4'b0010 : cmd, rn, v2, ci, r, f);
    ba = pcv + 32'(4 * int'($signed(simm)));
    @(negedge clk);
    chk("alu_result", alu_result, r);
    chk("br_addr", br_addr, ba);
    chk("branch_taken", {31'd0, branch_taken}, {31'd0, bi});
    chk("stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    if (si && !bi) status_m = f;
    chk("status", {28'd0, status}, {28'd0, status_m});
  endtask

  task automatic run_mul(input logic [31:0] rn, input logic [31:0] rm, input logic [11:0] so,
                         input logic si);
    logic [31:0] v2, prod;
    int exp_cyc, cyc, bl;
    exe_cmd = 4'b1010; s = si; b = 1'b0; mem_r = 1'b0; mem_w = 1'b0; imm = 1'b0;
    shift_operand = so; val_rn = rn; val_rm = rm; carry_in = 1'b0;
    v2 = m_val2(1'b0, 1'b0, so, rm);
    prod = rn * v2;
`ifdef MUL_EARLY_TERM_EN
    bl = 0;
    for (int i = 0; i < 32; i++) if (v2[i]) bl = i + 1;
    exp_cyc = 1 + ((bl == 0) ? 1 : bl);
`else
    bl = 0;
    exp_cyc = 33 + bl;
`endif
    cyc = 0;
    @(negedge clk);
    while (stall === 1'b1 && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
    chk("mul_stall_cycles", cyc, exp_cyc);
    chk("mul_result", alu_result, prod);
    @(posedge clk); #1;
    if (si) status_m = {prod[31], prod == 32'd0, status_m[1:0]};
    chk("mul_status", {28'd0, status}, {28'd0, status_m});
  endtask

  initial begin
    logic [3:0] cmds [9];
    logic [3:0] c;
    logic mr, mw, bi, si;
    cmds = '{4'b0001, 4'b1001, 4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b0110, 4'b0111, 4'b1000};
    rst = 1'b0; exe_cmd = 4'b1010; s = 1'b0; b = 1'b0; mem_r = 1'b0; mem_w = 1'b0; imm = 1'b0;
    shift_operand = 12'd0; signed_imm = 24'd0; val_rn = 32'd0; val_rm = 32'd0; pc = 32'd0;
    carry_in = 1'b0;
    #3;
    chk("reset_status", {28'd0, status}, 32'd0);
    chk("reset_stall", {31'd0, stall}, 32'd0);
    exe_cmd = 4'b0000;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    run_op(4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h003, 24'd0, 32'd5, 32'd0, 32'd0, 1'b0);
    chk("plan_add_imm", alu_result, 32'd8);
    run_op(4'b0100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 24'd0, 32'd3, 32'd3, 32'd0, 1'b0);
    chk("plan_sub_zero", alu_result, 32'd0);
    chk("plan_sub_flags", {28'd0, status}, 32'h6);
    run_op(4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 24'd0, 32'h7FFFFFFF, 32'd1, 32'd0, 1'b0);
    chk("plan_add_ovf_flags", {28'd0, status}, 32'h9);
    run_op(4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h1FF, 24'd0, 32'd0, 32'd0, 32'd0, 1'b0);
    chk("plan_rot_imm", alu_result, 32'hC000003F);
    run_op(4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h240, 24'd0, 32'd0, 32'h80000000, 32'd0, 1'b0);
    chk("plan_asr4", alu_result, 32'hF8000000);
    run_op(4'b0011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 24'd0, 32'd1, 32'd1, 32'd0, 1'b1);
    chk("plan_adc", alu_result, 32'd3);
    run_op(4'b0101, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 24'd0, 32'd5, 32'd2, 32'd0, 1'b0);
    chk("plan_sbc", alu_result, 32'd2);
    run_op(4'b0100, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 24'hFFFFFE, 32'd0, 32'd1, 32'h100, 1'b0);
    chk("plan_br_addr", br_addr, 32'hF8);
    chk("plan_br_status_kept", {28'd0, status}, 32'h9);
    run_op(4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h004, 24'd0, 32'h1000, 32'd9, 32'd0, 1'b0);
    chk("plan_ld_addr", alu_result, 32'h1004);
    run_op(4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 24'd0, 32'd1, 32'd1, 32'd0, 1'b0);
    run_mul(32'd7, 32'd6, 12'h000, 1'b1);
    chk("plan_mul_status", {28'd0, status}, 32'h0);
    run_mul(32'hFFFFFFFF, 32'd3, 12'h000, 1'b1);
    run_mul(32'd12345, 32'd0, 12'h000, 1'b1);

    // Mid-BUSY async reset with MUL still presented
    run_op(4'b0100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 24'd0, 32'd3, 32'd3, 32'd0, 1'b0);
    exe_cmd = 4'b1010; s = 1'b1; val_rn = 32'd7; val_rm = 32'hFFFFFFFF; shift_operand = 12'h000;
    repeat (11) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midbusy_reset_stall", {31'd0, stall}, 32'd0);
    chk("midbusy_reset_status", {28'd0, status}, 32'd0);
    status_m = 4'b0000;
    exe_cmd = 4'b0010;
    @(negedge clk);
    rst = 1'b1;
    run_op(4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h003, 24'd0, 32'd5, 32'd0, 32'd0, 1'b0);
    chk("post_reset_add", alu_result, 32'd8);

    for (int i = 0; i < 300; i++) begin
      c  = cmds[$urandom_range(0, 8)];
      mr = ($urandom_range(0, 7) == 0);
      mw = !mr && ($urandom_range(0, 7) == 0);
      bi = !(mr || mw) && ($urandom_range(0, 3) == 0);
      si = !(mr || mw) && ($urandom_range(0, 1) == 1);
      run_op(c, si, bi, mr, mw, 1'($urandom_range(0, 1)), 12'($urandom), 24'($urandom),
             $urandom, ($urandom_range(0, 3) == 0) ? 32'h80000000 : $urandom, $urandom,
             1'($urandom_range(0, 1)));
      if (i % 40 == 0) run_mul($urandom, 32'($urandom_range(0, 255)), 12'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
